decode_stage: RTL
=================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of PC and immediate datapath; SHALL be 32 or 64.
REQ-002 Parameter FIFO_DEPTH, default 2: instruction buffer entries; SHALL be a power of two, >=2.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset, with ports named as the codebase does:
  clk  in  1  clock, rising edge
  rst  in  1  asynchronous active-high reset
REQ-004 Input ports SHALL be:
  flush_i       in  1           discard all buffered and output-held instructions
  instr_valid_i in  1           fetch offers instruction
  instr_i       in  32          raw RV32 instruction word
  instr_pc_i    in  DATA_WIDTH  PC of instr_i
  dec_ready_i   in  1           execute accepts decoded bundle
REQ-005 Output ports SHALL be:
  instr_ready_o   out 1           buffer can accept
  dec_valid_o     out 1           decoded bundle valid
  dec_pc_o        out DATA_WIDTH  PC of bundle
  alu_operator_o  out alu_opcode_e  ALU operation
  imm_o           out DATA_WIDTH  sign/zero-extended immediate
  imm_valid_o     out 1           immediate present
  rs1_o/rs2_o/rd_o  out 5 each    register indices
  rs_rd_used_o    out 3           {rd_used, rs2_used, rs1_used}
  ctrl_o          out dec_ctrl_t  mux selects, ctrl-transfer kind, LSU req/type/we/sign_ext
  instr_invalid_o out 1           instruction not legal in configured ISA

Function
REQ-006 Handshake: transfer on valid&&ready at rising clk; instr_ready_o SHALL equal !full, derived from registered count only (no combinational path from dec_ready_i).
REQ-007 Buffer: FIFO_DEPTH-entry circular FIFO of {instr, pc}; read/write pointers wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.
REQ-008 Output register SHALL load decoded FIFO head when FIFO non-empty and (!dec_valid_o || dec_ready_i); otherwise it SHALL hold all outputs stable.
REQ-009 dec_valid_o SHALL clear when dec_ready_i=1 and the FIFO is empty.
REQ-010 Latency: instruction accepted at edge N into an empty stage SHALL appear with dec_valid_o=1 after edge N+1; no bypass path.
REQ-011 Throughput: with dec_ready_i held high, one bundle per cycle sustained.
REQ-012 Push while full is impossible by REQ-006; push and pop in the same cycle at any non-full level SHALL leave count unchanged.
REQ-013 Decode SHALL cover RV32I R, I, LUI, AUIPC, B, JAL, JALR, LOAD, STORE encodings with RISC-V immediate formats, sign-extended to DATA_WIDTH.
REQ-014 Shift-immediates SHALL zero-extend shamt[4:0]; SLLI/SRLI/SRAI with funct7 other than 0000000/0100000 SHALL set instr_invalid_o.
REQ-015 Undefined opcode/funct3 SHALL set instr_invalid_o=1, leaving all *_used bits and data_req at 0; the bundle is still delivered with dec_valid_o=1.
REQ-016 Flush (synchronous): flush_i=1 at edge SHALL empty FIFO, clear dec_valid_o and drop any same-cycle push; flush SHALL dominate push and pop.

Reset
REQ-017 While rst=1: pointers and count SHALL be 0, dec_valid_o=0, and instr_ready_o=1 after the first edge with rst deasserted.
REQ-018 While rst=1: all bundle outputs SHALL be 0, instr_invalid_o=0, and ctrl_o=all-zero.
REQ-019 Reset asserted mid-stream SHALL discard all buffered instructions immediately, without waiting for a clock edge.

Configuration
REQ-020 Macro TOOTHLESS_RV32M_EN defined: R-type with funct7=0000001 SHALL decode to ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU per funct3.
REQ-021 Macro TOOTHLESS_RV32M_EN undefined: those encodings SHALL set instr_invalid_o=1, and the M enumerators SHALL be unused.

Structure
REQ-022 toothless_pkg SHALL hold dec_ctrl_t, the M-extension alu_opcode_e members, and opcode/funct constants.
REQ-023 The FIFO SHALL be sub-module decode_fifo (params WIDTH, DEPTH); decode logic SHALL be one always_comb in decode_stage.

Verification
REQ-024 Push 0xFFF10093 (addi x1,x2,-1), PC 0x100, at edge N -> after N+1: dec_valid_o=1, ALU_ADD, imm_o=all ones, rs1=2, rd=1, rs_rd_used=3'b101, dec_pc_o=0x100.
REQ-025 FIFO_DEPTH=2, dec_ready_i=0, offer 4 instructions -> 3 accepted, instr_ready_o=0; raise dec_ready_i -> in-order delivery, one per cycle.
REQ-026 Push 0x022081B3 (mul x3,x1,x2) -> with TOOTHLESS_RV32M_EN: ALU_MUL, instr_invalid_o=0; without: instr_invalid_o=1.
REQ-027 Push 0x00000000 -> dec_valid_o=1, instr_invalid_o=1, data_req=0.
REQ-028 Fill 2 entries plus output held, assert flush_i together with a push -> next cycle dec_valid_o=0, count=0, pushed word never delivered.
REQ-029 Assert rst asynchronously mid-stream -> outputs reach REQ-017/REQ-018 values before the next edge; first post-reset push is delivered correctly.

Source files
------------

// File: rtl/toothless_pkg.sv
// Shared types and encodings for the toothless decode stage.
// ALU_MUL..ALU_REMU are only produced when TOOTHLESS_RV32M_EN is defined.
package toothless_pkg;

    typedef enum logic [4:0] {
        ALU_ADD, ALU_SUB, ALU_XOR, ALU_OR, ALU_AND, ALU_SLL, ALU_SRL, ALU_SRA,
        ALU_SLT, ALU_SLTU, ALU_EQ, ALU_NE, ALU_LT, ALU_GE, ALU_LTU, ALU_GEU,
        ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
    } alu_opcode_e;

    typedef enum logic [1:0] {OPA_REG, OPA_PC, OPA_ZERO} op_a_sel_e;
    typedef enum logic       {OPB_REG, OPB_IMM} op_b_sel_e;
    typedef enum logic [1:0] {CT_NONE, CT_BRANCH, CT_JAL, CT_JALR} ctrl_transfer_e;
    typedef enum logic [1:0] {DT_BYTE, DT_HALF, DT_WORD} data_type_e;

    typedef struct packed {
        op_a_sel_e      op_a_sel;
        op_b_sel_e      op_b_sel;
        ctrl_transfer_e ctrl_transfer;
        logic           data_req;
        data_type_e     data_type;
        logic           data_we;
        logic           data_sign_ext;
    } dec_ctrl_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

endpackage

// File: rtl/decode_fifo.sv
// Circular instruction buffer; flush and reset empty it by clearing pointers and count.
module decode_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage carries no reset; only entries behind a valid count are ever read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: instruction FIFO, combinational decode of the head, registered bundle.
// Define TOOTHLESS_RV32M_EN to decode the M-extension R-type encodings.
module decode_stage
    import toothless_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic                  instr_valid_i,
    input  logic [31:0]           instr_i,
    input  logic [DATA_WIDTH-1:0] instr_pc_i,
    input  logic                  dec_ready_i,
    output logic                  instr_ready_o,
    output logic                  dec_valid_o,
    output logic [DATA_WIDTH-1:0] dec_pc_o,
    output alu_opcode_e           alu_operator_o,
    output logic [DATA_WIDTH-1:0] imm_o,
    output logic                  imm_valid_o,
    output logic [4:0]            rs1_o,
    output logic [4:0]            rs2_o,
    output logic [4:0]            rd_o,
    output logic [2:0]            rs_rd_used_o,
    output dec_ctrl_t             ctrl_o,
    output logic                  instr_invalid_o
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_WIDTH+31:0] fifo_rdata;
    logic [CNT_W-1:0]       fifo_count;
    logic                   fifo_empty;
    logic                   load;
    logic [31:0]            instr;

    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic [6:0]         funct7;
    logic signed [31:0] imm32;
    alu_opcode_e        d_alu;
    logic               d_imm_valid;
    logic [2:0]         d_used;
    dec_ctrl_t          d_ctrl;
    logic               d_invalid;

    assign instr         = fifo_rdata[31:0];
    assign fifo_empty    = (fifo_count == '0);
    assign instr_ready_o = (fifo_count != CNT_W'(FIFO_DEPTH));
    assign load          = !fifo_empty && (!dec_valid_o || dec_ready_i);

    decode_fifo #(
        .WIDTH (DATA_WIDTH + 32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush_i),
        .push  (instr_valid_i && instr_ready_o),
        .wdata ({instr_pc_i, instr_i}),
        .pop   (load),
        .rdata (fifo_rdata),
        .count (fifo_count)
    );

    always_comb begin
        opcode      = instr[6:0];
        funct3      = instr[14:12];
        funct7      = instr[31:25];
        imm32       = '0;
        d_alu       = ALU_ADD;
        d_imm_valid = 1'b0;
        d_used      = 3'b000;
        d_ctrl      = '0;
        d_invalid   = 1'b0;
        case (opcode)
            OPC_LUI, OPC_AUIPC: begin
                d_ctrl.op_a_sel = (opcode == OPC_LUI) ? OPA_ZERO : OPA_PC;
                d_ctrl.op_b_sel = OPB_IMM;
                imm32           = {instr[31:12], 12'b0};
                d_imm_valid     = 1'b1;
                d_used          = 3'b100;
            end
            OPC_JAL: begin
                d_ctrl.op_a_sel      = OPA_PC;
                d_ctrl.op_b_sel      = OPB_IMM;
                d_ctrl.ctrl_transfer = CT_JAL;
                imm32       = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
                d_imm_valid = 1'b1;
                d_used      = 3'b100;
            end
            OPC_JALR: begin
                d_ctrl.op_b_sel      = OPB_IMM;
                d_ctrl.ctrl_transfer = CT_JALR;
                imm32       = {{20{instr[31]}}, instr[31:20]};
                d_imm_valid = 1'b1;
                d_used      = 3'b101;
                d_invalid   = (funct3 != 3'b000);
            end
            OPC_BRANCH: begin
                d_ctrl.ctrl_transfer = CT_BRANCH;
                imm32       = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
                d_imm_valid = 1'b1;
                d_used      = 3'b011;
                case (funct3)
                    3'b000:  d_alu = ALU_EQ;
                    3'b001:  d_alu = ALU_NE;
                    3'b100:  d_alu = ALU_LT;
                    3'b101:  d_alu = ALU_GE;
                    3'b110:  d_alu = ALU_LTU;
                    3'b111:  d_alu = ALU_GEU;
                    default: d_invalid = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                d_ctrl.op_b_sel      = OPB_IMM;
                d_ctrl.data_req      = 1'b1;
                d_ctrl.data_sign_ext = !funct3[2];
                imm32       = {{20{instr[31]}}, instr[31:20]};
                d_imm_valid = 1'b1;
                d_used      = 3'b101;
                case (funct3)
                    3'b000, 3'b100: d_ctrl.data_type = DT_BYTE;
                    3'b001, 3'b101: d_ctrl.data_type = DT_HALF;
                    3'b010:         d_ctrl.data_type = DT_WORD;
                    default:        d_invalid = 1'b1;
                endcase
            end
            OPC_STORE: begin
                d_ctrl.op_b_sel = OPB_IMM;
                d_ctrl.data_req = 1'b1;
                d_ctrl.data_we  = 1'b1;
                imm32       = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                d_imm_valid = 1'b1;
                d_used      = 3'b011;
                case (funct3)
                    3'b000:  d_ctrl.data_type = DT_BYTE;
                    3'b001:  d_ctrl.data_type = DT_HALF;
                    3'b010:  d_ctrl.data_type = DT_WORD;
                    default: d_invalid = 1'b1;
                endcase
            end
            OPC_OP_IMM: begin
                d_ctrl.op_b_sel = OPB_IMM;
                imm32       = {{20{instr[31]}}, instr[31:20]};
                d_imm_valid = 1'b1;
                d_used      = 3'b101;
                case (funct3)
                    3'b000: d_alu = ALU_ADD;
                    3'b010: d_alu = ALU_SLT;
                    3'b011: d_alu = ALU_SLTU;
                    3'b100: d_alu = ALU_XOR;
                    3'b110: d_alu = ALU_OR;
                    3'b111: d_alu = ALU_AND;
                    3'b001: begin
                        imm32     = {27'b0, instr[24:20]};
                        d_alu     = ALU_SLL;
                        d_invalid = (funct7 != F7_BASE);
                    end
                    default: begin
                        imm32     = {27'b0, instr[24:20]};
                        d_alu     = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                        d_invalid = (funct7 != F7_BASE) && (funct7 != F7_ALT);
                    end
                endcase
            end
            OPC_OP: begin
                d_used = 3'b111;
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        3'b000:  d_alu = ALU_ADD;
                        3'b001:  d_alu = ALU_SLL;
                        3'b010:  d_alu = ALU_SLT;
                        3'b011:  d_alu = ALU_SLTU;
                        3'b100:  d_alu = ALU_XOR;
                        3'b101:  d_alu = ALU_SRL;
                        3'b110:  d_alu = ALU_OR;
                        default: d_alu = ALU_AND;
                    endcase
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    d_alu = ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    d_alu = ALU_SRA;
`ifdef TOOTHLESS_RV32M_EN
                end else if (funct7 == F7_MULDIV) begin
                    case (funct3)
                        3'b000:  d_alu = ALU_MUL;
                        3'b001:  d_alu = ALU_MULH;
                        3'b010:  d_alu = ALU_MULHSU;
                        3'b011:  d_alu = ALU_MULHU;
                        3'b100:  d_alu = ALU_DIV;
                        3'b101:  d_alu = ALU_DIVU;
                        3'b110:  d_alu = ALU_REM;
                        default: d_alu = ALU_REMU;
                    endcase
`endif
                end else begin
                    d_invalid = 1'b1;
                end
            end
            default: d_invalid = 1'b1;
        endcase
        // Illegal encodings deliver an inert bundle: no operands, no memory request.
        if (d_invalid) begin
            imm32       = '0;
            d_alu       = ALU_ADD;
            d_imm_valid = 1'b0;
            d_used      = 3'b000;
            d_ctrl      = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_valid_o     <= 1'b0;
            dec_pc_o        <= '0;
            alu_operator_o  <= ALU_ADD;
            imm_o           <= '0;
            imm_valid_o     <= 1'b0;
            rs1_o           <= '0;
            rs2_o           <= '0;
            rd_o            <= '0;
            rs_rd_used_o    <= '0;
            ctrl_o          <= '0;
            instr_invalid_o <= 1'b0;
        end else if (flush_i) begin
            dec_valid_o <= 1'b0;
        end else if (load) begin
            dec_valid_o     <= 1'b1;
            dec_pc_o        <= fifo_rdata[DATA_WIDTH+31:32];
            alu_operator_o  <= d_alu;
            imm_o           <= DATA_WIDTH'(imm32);
            imm_valid_o     <= d_imm_valid;
            rs1_o           <= d_used[0] ? instr[19:15] : 5'd0;
            rs2_o           <= d_used[1] ? instr[24:20] : 5'd0;
            rd_o            <= d_used[2] ? instr[11:7]  : 5'd0;
            rs_rd_used_o    <= d_used;
            ctrl_o          <= d_ctrl;
            instr_invalid_o <= d_invalid;
        end else if (dec_ready_i) begin
            dec_valid_o <= 1'b0;
        end
    end

endmodule
